// File: rtl/gain_slew_limiter_if.sv
// Gain limiter bus: control-code/tick/mute inputs toward the limiter, gain and status back.
// The limiter has no backpressure: the code and tick strobes are one-cycle
// pulses that the slave always accepts; mult_o/settled_o are plain registered levels.
interface gain_slew_limiter_if #(
  parameter int MULT_W = 9,
  parameter int KNOB_W = 12
);
  logic [KNOB_W-1:0]        knob_i;
  logic                     knob_valid_i;
  logic                     sample_tick_i;
  logic                     mute_i;
  logic signed [MULT_W-1:0] mult_o;
  logic                     settled_o;
  logic [1:0]               state_o;

  modport master (
    output knob_i, knob_valid_i, sample_tick_i, mute_i,
    input  mult_o, settled_o, state_o
  );

  modport slave (
    input  knob_i, knob_valid_i, sample_tick_i, mute_i,
    output mult_o, settled_o, state_o
  );
endinterface

// File: rtl/gain_slew_limiter.sv
// Slew-limited gain control: turns a raw control code into a multiplier that
// ramps toward its target by at most STEP per audio sample tick, with a
// hysteresis dead band on the input code and a mute that ramps down to zero.
// The code register and mute are registered, so every input change takes effect from the
// following cycle and state/settled can be registered from next-cycle values.
module gain_slew_limiter #(
  parameter int MULT_W = 9,
  parameter int KNOB_W = 12,
  parameter int STEP   = 4,
  parameter int HYST   = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  gain_slew_limiter_if.slave bus
);
  localparam int VW    = MULT_W - 1;
  localparam int SHIFT = KNOB_W - VW;

  // state_o encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  logic [VW-1:0]     scaled;
  logic [VW-1:0]     knob_diff;
  logic [VW-1:0]     knob_q;
  logic [VW-1:0]     knob_nx;
  logic [VW-1:0]     target;
  logic [VW-1:0]     target_nx;
  logic              mute_q;
  logic [MULT_W-1:0] mult_q;
  logic [MULT_W-1:0] mult_nx;
  logic [MULT_W:0]   step_w;
  logic [MULT_W:0]   tgt_w;
  logic [MULT_W:0]   up_sum;
  logic [MULT_W:0]   dn_lim;
  logic [1:0]        state_q;
  logic [1:0]        state_nx;
  logic              settled_q;

  // Input code scaling and hysteresis: accept a new code only if it moves more than HYST.
  always_comb begin
    scaled    = VW'(bus.knob_i >> SHIFT);
    knob_diff = (scaled >= knob_q) ? (scaled - knob_q) : (knob_q - scaled);
    knob_nx   = knob_q;
    if (bus.knob_valid_i && (knob_diff > VW'(HYST))) begin
      knob_nx = scaled;
    end
    target    = mute_q ? '0 : knob_q;
    target_nx = bus.mute_i ? '0 : knob_nx;
  end

  // Ramp step: sums are one bit wider than mult so they can never wrap,
  // and "mult - STEP < target" is tested as "mult < target + STEP".
  always_comb begin
    step_w  = (MULT_W+1)'(STEP);
    tgt_w   = (MULT_W+1)'(target);
    up_sum  = {1'b0, mult_q} + step_w;
    dn_lim  = tgt_w + step_w;
    mult_nx = mult_q;
    if (bus.sample_tick_i) begin
      case (state_q)
        UP:      mult_nx = (up_sum > tgt_w) ? MULT_W'(target) : up_sum[MULT_W-1:0];
        DOWN:    mult_nx = ({1'b0, mult_q} < dn_lim) ? MULT_W'(target)
                                                     : (mult_q - MULT_W'(STEP));
        default: mult_nx = mult_q;
      endcase
    end
  end

  // Next direction, computed from the values all registers will hold next cycle.
  always_comb begin
    state_nx = IDLE;
    if (mult_nx < {1'b0, target_nx}) begin
      state_nx = UP;
    end else if (mult_nx > {1'b0, target_nx}) begin
      state_nx = DOWN;
    end
  end

  // State registers; reset lands on zero gain, zero code register, settled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      knob_q    <= '0;
      mute_q    <= 1'b0;
      mult_q    <= '0;
      state_q   <= IDLE;
      settled_q <= 1'b1;
    end else begin
      knob_q    <= knob_nx;
      mute_q    <= bus.mute_i;
      mult_q    <= mult_nx;
      state_q   <= state_nx;
      settled_q <= (state_nx == IDLE);
    end
  end

  assign bus.mult_o    = mult_q;
  assign bus.settled_o = settled_q;
  assign bus.state_o   = state_q;
endmodule

// File: tb/tb_gain_slew_limiter.sv
// Testbench for gain_slew_limiter: directed scenarios plus a random phase,
// with a reference model of target/ramp behaviour and a tick-driven scoreboard.
module tb_gain_slew_limiter;
  localparam int MULT_W = 9;
  localparam int KNOB_W = 12;
  localparam int STEP   = 4;
  localparam int HYST   = 2;
  localparam int SHIFT  = KNOB_W - (MULT_W - 1);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gain_slew_limiter_if #(.MULT_W(MULT_W), .KNOB_W(KNOB_W)) bus ();

  gain_slew_limiter #(.MULT_W(MULT_W), .KNOB_W(KNOB_W), .STEP(STEP), .HYST(HYST)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: gain, accepted control code, effective mute
  int model_mult = 0;
  int model_knob = 0;
  bit model_mute = 1'b0;
  bit mute_cur   = 1'b0;
  bit mon_en     = 1'b0;
  bit tick_d     = 1'b0;
  int exp_hold   = 0;
  logic [MULT_W-1:0] exp_q[$];

  function automatic int model_target();
    return model_mute ? 0 : model_knob;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present inputs for one cycle, then advance the model at the edge
  task automatic cyc(input bit v, input int k, input bit t);
    int tgt;
    int s;
    int d;
    bus.knob_valid_i  = v;
    bus.knob_i        = KNOB_W'(k);
    bus.sample_tick_i = t;
    bus.mute_i        = mute_cur;
    @(posedge clk);
    if (t) begin
      tgt = model_target();
      if (model_mult < tgt) model_mult = (model_mult + STEP > tgt) ? tgt : model_mult + STEP;
      else if (model_mult > tgt) model_mult = (model_mult - STEP < tgt) ? tgt : model_mult - STEP;
      exp_q.push_back(MULT_W'(model_mult));
    end
    if (v) begin
      s = k >> SHIFT;
      d = s - model_knob;
      if (d < 0) d = -d;
      if (d > HYST) model_knob = s;
    end
    model_mute = mute_cur;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0);
  endtask

  task automatic strobe(input int k);
    cyc(1'b1, k, 1'b0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      cyc(1'b0, 0, 1'b1);
    end
  endtask

  // async reset asserted between edges; outputs must clear before any edge
  task automatic do_reset();
    idle();
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mult", bus.mult_o, 0);
    check("rst_settled", bus.settled_o, 1);
    check("rst_state", bus.state_o, 0);
    model_mult = 0;
    model_knob = 0;
    model_mute = 1'b0;
    exp_q.delete();
    exp_hold = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // scoreboard monitor
  always @(posedge clk) tick_d <= bus.sample_tick_i;

  always @(negedge clk) begin
    int tgt;
    if (mon_en && rst_n) begin
      tgt = model_target();
      if (tick_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=output required=expected_entry at %0t", $time);
        end else begin
          exp_hold = int'(exp_q.pop_front());
          check("tick_mult", bus.mult_o, exp_hold);
        end
      end else begin
        check("hold_mult", bus.mult_o, exp_hold);
      end
      check("settled", bus.settled_o, (model_mult == tgt) ? 1 : 0);
      check("state", bus.state_o, (model_mult < tgt) ? 1 : (model_mult > tgt) ? 2 : 0);
    end
  end

  initial begin
    bus.knob_i        = '0;
    bus.knob_valid_i  = 1'b0;
    bus.sample_tick_i = 1'b0;
    bus.mute_i        = 1'b0;
    #12;
    check("por_mult", bus.mult_o, 0);
    check("por_settled", bus.settled_o, 1);
    check("por_state", bus.state_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // fade-in from reset
    strobe(4095);
    tick_n(64);
    check("fade_end", bus.mult_o, 255);
    check("fade_settled", bus.settled_o, 1);

    // hysteresis around code register = 128
    strobe(2048);
    tick_n(40);
    check("hyst_base", bus.mult_o, 128);
    strobe(2056); tick_n(3);
    strobe(2072); tick_n(3);
    strobe(2080); tick_n(3);
    check("hyst_hold", bus.mult_o, 128);
    strobe(2096); tick_n(3);
    check("hyst_move", bus.mult_o, 131);

    // mute ramp down and back up
    strobe(4095);
    tick_n(40);
    check("mute_pre", bus.mult_o, 255);
    mute_cur = 1'b1; idle();
    tick_n(63);
    check("mute_near0", bus.mult_o, 3);
    tick_n(1);
    check("mute_zero", bus.mult_o, 0);
    mute_cur = 1'b0; idle();
    tick_n(64);
    check("unmute_full", bus.mult_o, 255);
    mute_cur = 1'b1; idle();
    tick_n(64);
    strobe(1024);
    idle();
    mute_cur = 1'b0; idle();
    tick_n(20);
    check("unmute_new_level", bus.mult_o, 64);

    // redirect mid-ramp
    strobe(4095);
    tick_n(9);
    check("redir_at100", bus.mult_o, 100);
    strobe(1024);
    tick_n(12);
    check("redir_end", bus.mult_o, 64);
    check("redir_settled", bus.settled_o, 1);

    // strobe and tick in the same cycle
    strobe(0);
    tick_n(20);
    check("simul_pre", bus.mult_o, 0);
    cyc(1'b1, 4095, 1'b1);
    check("simul_same", bus.mult_o, 0);
    idle();
    cyc(1'b0, 0, 1'b1);
    check("simul_next", bus.mult_o, 4);

    // random phase
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit t;
      v = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 2) == 0);
      if (!t && ($urandom_range(0, 29) == 0)) mute_cur = ~mute_cur;
      cyc(v, int'($urandom_range(0, 4095)), t);
    end
    mute_cur = 1'b0;
    idle();

    // asynchronous reset mid-ramp, then ticks without a strobe
    do_reset();
    strobe(4095);
    tick_n(30);
    check("ramp_120", bus.mult_o, 120);
    do_reset();
    tick_n(10);
    check("post_rst_mult", bus.mult_o, 0);
    check("post_rst_settled", bus.settled_o, 1);

    idle();
    idle();
    check("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
